wide_data_mem: RTL and testbench

Parametrised synchronous data memory for the Troy WideWord processor, successor to the fixed 256 x 128-bit data memory. It adds configurable word width, depth and read latency, per-byte write enables, a valid/ready request handshake, out-of-range address detection and an optional post-reset clear sweep. It sits between the MEM pipeline stage and the register-file writeback path.

---
 rtl/wide_data_mem.sv | 168 ++++++++++++++++
 tb/tb_wide_data_mem.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_data_mem.sv
// rtl/wide_data_mem.sv - parametrised byte-enabled data memory with pipelined loads; optional clear sweep under DMEM_INIT_CLEAR_EN
module wide_data_mem #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            dm_ctrl_sig,
    input  logic [31:0]           mem_ctrl_addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  addr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    localparam logic [1:0] OP_LD = 2'b01;
    localparam logic [1:0] OP_ST = 2'b10;

    // Elaboration-time guards on the parameter ranges
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("wide_data_mem: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 2 || DEPTH > 65536 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("wide_data_mem: DEPTH must be a power of two in 2..65536");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("wide_data_mem: RD_LAT must be in 1..4");
    end

    logic [DATA_W-1:0] mem_array [DEPTH];

    logic                          ready_q, ready_d;
    logic                          addr_err_q, addr_err_d;
    logic [RD_LAT-1:0]             vld_q, vld_d;
    logic [RD_LAT-1:0][DATA_W-1:0] dat_q, dat_d;

    logic          req_acc;
    logic          in_range;
    logic          ld_acc;
    logic          st_acc;
    logic [AW-1:0] word_idx;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;

    // Request decode: acceptance, range check and operation type
    always_comb begin
        req_acc  = req_valid & ready_q;
        in_range = (mem_ctrl_addr[31:AW] == '0);
        word_idx = mem_ctrl_addr[AW-1:0];
        ld_acc   = req_acc && (dm_ctrl_sig == OP_LD);
        st_acc   = req_acc && (dm_ctrl_sig == OP_ST);
    end

`ifdef DMEM_INIT_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    // Sweep FSM: walk every address once, then sit in RUN until reset
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
        ready_d = (state_d == ST_RUN);
    end

    // Sweep state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Write port mux: the sweep owns the port while requests are blocked
    always_comb begin
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt_q;
            wr_data = '0;
            wr_be   = '1;
        end else begin
            wr_en   = st_acc && in_range;
            wr_addr = word_idx;
            wr_data = data_in;
            wr_be   = byte_en;
        end
    end
`else
    // Without the sweep the block is ready from the first edge after reset
    always_comb begin
        ready_d = 1'b1;
    end

    // Write port driven only by accepted in-range stores
    always_comb begin
        wr_en   = st_acc && in_range;
        wr_addr = word_idx;
        wr_data = data_in;
        wr_be   = byte_en;
    end
`endif

    // Load pipeline and error pulse: stage 0 captures the array word on acceptance
    always_comb begin
        vld_d      = vld_q;
        dat_d      = dat_q;
        vld_d[0]   = ld_acc;
        dat_d[0]   = (ld_acc && in_range) ? mem_array[word_idx] : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        addr_err_d = (ld_acc || st_acc) && !in_range;
    end

    // Control and pipeline registers; reset drops every in-flight load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
            vld_q      <= '0;
            dat_q      <= '0;
        end else begin
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
            vld_q      <= vld_d;
            dat_q      <= dat_d;
        end
    end

    // Array write with per-byte lane enables; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem_array[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = ready_q;
    assign rd_valid  = vld_q[RD_LAT-1];
    assign data_out  = vld_q[RD_LAT-1] ? dat_q[RD_LAT-1] : '0;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_wide_data_mem.sv
// tb/tb_wide_data_mem.sv - self-checking bench for wide_data_mem
module tb_wide_data_mem;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 3;
    localparam int NB     = DATA_W / 8;
    localparam int MAXC   = 8192;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        dm_ctrl_sig;
    logic [31:0]       mem_ctrl_addr;
    logic [DATA_W-1:0] data_in;
    logic [NB-1:0]     byte_en;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              addr_err;

    wide_data_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .dm_ctrl_sig   (dm_ctrl_sig),
        .mem_ctrl_addr (mem_ctrl_addr),
        .data_in       (data_in),
        .byte_en       (byte_en),
        .data_out      (data_out),
        .rd_valid      (rd_valid),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Expected outputs for the cycle following edge k
    bit                exp_v [MAXC];
    bit                exp_e [MAXC];
    logic [DATA_W-1:0] exp_d [MAXC];

    // Reference memory image
    logic [DATA_W-1:0] model [DEPTH];

    typedef struct {
        logic [1:0]        op;
        logic [31:0]       addr;
        logic [DATA_W-1:0] data;
        logic [NB-1:0]     be;
        logic [DATA_W-1:0] exp_data;
        bit                exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i] = 1'b0;
            exp_e[i] = 1'b0;
            exp_d[i] = '0;
        end
    endtask

    // Per-cycle output check while the block is in normal operation
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc >= MAXC) begin
                chk("cycle_budget", DATA_W'(cyc), DATA_W'(MAXC - 1));
            end else begin
                chk($sformatf("rd_valid@%0d", cyc), DATA_W'(rd_valid), DATA_W'(exp_v[cyc]));
                chk($sformatf("data_out@%0d", cyc), data_out, exp_d[cyc]);
                chk($sformatf("addr_err@%0d", cyc), DATA_W'(addr_err), DATA_W'(exp_e[cyc]));
                chk($sformatf("req_ready@%0d", cyc), DATA_W'(req_ready), DATA_W'(1));
            end
        end
    end

    // Drive one request for one cycle and record what the spec predicts for it
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [DATA_W-1:0] d,
                         input logic [NB-1:0] be, input bit use_tab,
                         input logic [DATA_W-1:0] t_data, input bit t_err);
        int k;
        int idx;
        bit inr;
        logic [DATA_W-1:0] e;
        req_valid     = 1'b1;
        dm_ctrl_sig   = op;
        mem_ctrl_addr = a;
        data_in       = d;
        byte_en       = be;
        k   = cyc + 1;
        inr = (a < DEPTH);
        idx = int'(a % DEPTH);
        if (k + RD_LAT < MAXC) begin
            if (op == OP_LD) begin
                e = inr ? model[idx] : '0;
                if (use_tab) e = t_data;
                exp_v[k + RD_LAT - 1] = 1'b1;
                exp_d[k + RD_LAT - 1] = e;
                exp_e[k] = use_tab ? t_err : !inr;
            end else if (op == OP_ST) begin
                exp_e[k] = use_tab ? t_err : !inr;
            end
        end
        if (op == OP_ST && inr) begin
            for (int b = 0; b < NB; b++)
                if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        dm_ctrl_sig = OP_NOP;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count cycles with req_ready low after reset release (bounded)
    task automatic wait_ready(output int low);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        low = -1;
        for (int i = 0; i < 4 * DEPTH && !done; i++) begin
            @(posedge clk);
            #1;
            chk("no_rd_valid_during_init", DATA_W'(rd_valid), '0);
            if (req_ready) begin
                low = n + 1;
                done = 1'b1;
            end else begin
                n++;
            end
        end
    endtask

    task automatic reset_model();
`ifdef DMEM_INIT_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
    endtask

    localparam int EXP_LOW = 
`ifdef DMEM_INIT_CLEAR_EN
        DEPTH;
`else
        1;
`endif

    vec_t tab [16];
    int   n_tab;

    initial begin
        int low;
        logic [DATA_W-1:0] v_eeaa;
        logic [DATA_W-1:0] rnd;

        v_eeaa = 128'h00112233445566778899AABBCCDDEEAA;
        n_tab = 0;
        tab[n_tab++] = '{OP_ST,  32'd5,          128'h00112233445566778899AABBCCDDEEFF, 16'hFFFF, '0, 1'b0};
        tab[n_tab++] = '{OP_ST,  32'd5,          {16{8'hAA}},                           16'h0001, '0, 1'b0};
        tab[n_tab++] = '{OP_LD,  32'd5,          '0,                                    16'h0000, v_eeaa, 1'b0};
        tab[n_tab++] = '{OP_LD,  32'h100,        '0,                                    16'h0000, '0, 1'b1};
        tab[n_tab++] = '{OP_ST,  32'h8000_0000,  {16{8'hFF}},                           16'hFFFF, '0, 1'b1};
        tab[n_tab++] = '{OP_ST,  32'h8000_0005,  {16{8'hFF}},                           16'hFFFF, '0, 1'b1};
        tab[n_tab++] = '{OP_LD,  32'd5,          '0,                                    16'h0000, v_eeaa, 1'b0};
        tab[n_tab++] = '{OP_ST,  32'd7,          128'h1234,                             16'hFFFF, '0, 1'b0};
        tab[n_tab++] = '{OP_LD,  32'd7,          '0,                                    16'h0000, 128'h1234, 1'b0};
        tab[n_tab++] = '{OP_NOP, 32'd5,          {16{8'h11}},                           16'hFFFF, '0, 1'b0};
        tab[n_tab++] = '{OP_RSV, 32'd5,          {16{8'h22}},                           16'hFFFF, '0, 1'b0};
        tab[n_tab++] = '{OP_ST,  32'd5,          {16{8'h33}},                           16'h0000, '0, 1'b0};
        tab[n_tab++] = '{OP_LD,  32'd5,          '0,                                    16'h0000, v_eeaa, 1'b0};
        tab[n_tab++] = '{OP_ST,  32'd5,          128'h55 << 120,                        16'h8000, '0, 1'b0};
        tab[n_tab++] = '{OP_LD,  32'd5,          '0,                                    16'h0000, 128'h55112233445566778899AABBCCDDEEAA, 1'b0};
        tab[n_tab++] = '{OP_LD,  32'hFFFF_FFFF,  '0,                                    16'h0000, '0, 1'b1};

        clear_exp();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        dm_ctrl_sig = OP_NOP;
        mem_ctrl_addr = '0;
        data_in = '0;
        byte_en = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", DATA_W'(req_ready), '0);
        chk("reset_rd_valid",  DATA_W'(rd_valid),  '0);
        chk("reset_data_out",  data_out,           '0);
        chk("reset_addr_err",  DATA_W'(addr_err),  '0);

`ifdef DMEM_INIT_CLEAR_EN
        // Interrupt the sweep part-way; it must restart from address 0
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("ready_low_mid_sweep", DATA_W'(req_ready), '0);
        end
        rst_n = 1'b0;
        #2;
`endif
        rst_n = 1'b1;
        wait_ready(low);
        chk("init_ready_low_cycles", DATA_W'(low), DATA_W'(EXP_LOW));
        chk_en = 1'b1;

`ifdef DMEM_INIT_CLEAR_EN
        issue(OP_LD, 32'hFF, '0, '0, 1'b1, '0, 1'b0);
        issue(OP_LD, 32'h00, '0, '0, 1'b1, '0, 1'b0);
`endif

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            issue(OP_ST, 32'(i), rnd, 16'hFFFF, 1'b0, '0, 1'b0);
        end
        idle(2);

        // Directed vectors applied back to back
        for (int i = 0; i < n_tab; i++)
            issue(tab[i].op, tab[i].addr, tab[i].data, tab[i].be, 1'b1, tab[i].exp_data, tab[i].exp_err);
        idle(RD_LAT + 2);

        // Back-to-back load bursts separated by idle gaps
        for (int r = 0; r < 2; r++) begin
            issue(OP_LD, 32'd1, '0, '0, 1'b0, '0, 1'b0);
            issue(OP_LD, 32'd2, '0, '0, 1'b0, '0, 1'b0);
            issue(OP_LD, 32'd3, '0, '0, 1'b0, '0, 1'b0);
            idle(RD_LAT + 2);
        end

        // Randomised traffic against the reference image
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [NB-1:0] be;
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 15));
            be = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            issue(2'($urandom_range(0, 3)), a, rnd, be, 1'b0, '0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(RD_LAT + 2);

        // Reset one cycle after a load is accepted: the load must vanish
        issue(OP_LD, 32'd7, '0, '0, 1'b0, '0, 1'b0);
        idle(1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midload_rst_rd_valid",  DATA_W'(rd_valid),  '0);
        chk("midload_rst_data_out",  data_out,           '0);
        chk("midload_rst_addr_err",  DATA_W'(addr_err),  '0);
        chk("midload_rst_req_ready", DATA_W'(req_ready), '0);
        repeat (RD_LAT + 1) begin
            @(posedge clk);
            #1;
            chk("midload_no_rd_valid", DATA_W'(rd_valid), '0);
        end
        clear_exp();
        reset_model();
        rst_n = 1'b1;
        wait_ready(low);
        chk("rerelease_ready_low_cycles", DATA_W'(low), DATA_W'(EXP_LOW));
        chk_en = 1'b1;

        // Array contents survive reset unless the sweep clears them
        issue(OP_LD, 32'd7,  '0, '0, 1'b0, '0, 1'b0);
        issue(OP_LD, 32'd5,  '0, '0, 1'b0, '0, 1'b0);
        issue(OP_LD, 32'hFF, '0, '0, 1'b0, '0, 1'b0);
        idle(RD_LAT + 2);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
